instr_prefetch_buffer: RTL and testbench

- Instruction-fetch front end placed directly upstream of the pipelined core's IF stage.
- Issues word fetches to instruction memory over a req/gnt/rvalid bus and buffers returned words with their PCs in a small FIFO.
- Presents them to the core with a valid/ready handshake.
- On a taken branch/jump redirect it flushes buffered and in-flight instructions and restarts fetching at the new PC.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/instr_prefetch_buffer.sv | 109 ++++++++++
 tb/tb_instr_prefetch_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: data width, default reset PC and the
// {pc, instr} layout carried through the fetch buffer.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO with flush; the head entry is read
// straight from storage, so a push becomes visible the cycle after it lands.
module sync_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = fetch_entry_t,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  T              wdata_i,
  output T              rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !flush_i && !full_o;
  assign do_pop_s  = pop_i && !flush_i && !empty_o;

  // Pointer and occupancy next-state; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch front end: credit-limited word fetches, in-order
// response buffering with PCs, and flush/discard handling on redirect.
module instr_prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] return_pc_q, return_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] redirect_base_s;
  logic            req_s, grant_s, push_s, pop_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [CW-1:0]   fifo_count_s;
  fetch_entry_t    push_entry_s, head_s;
  logic            unused_pc_bits_s;

  assign unused_pc_bits_s = ^redirect_pc[1:0];
  assign redirect_base_s  = {redirect_pc[XLEN-1:2], 2'b00};

  // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
  assign req_s   = !rst && !redirect_valid &&
                   (({1'b0, fifo_count_s} + {1'b0, outstanding_q}) < CREDITS);
  assign grant_s = req_s && imem_gnt;
  assign push_s  = imem_rvalid && (discard_q == {CW{1'b0}}) && !redirect_valid && !fifo_full_s;
  assign pop_s   = !fifo_empty_s && out_ready && !redirect_valid;
  assign push_entry_s = '{pc: return_pc_q, instr: imem_rdata};

  // Fetch/return PCs and credit counters; a redirect restarts both PCs and
  // marks every still-outstanding response (minus one arriving now) for discard.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    return_pc_d   = return_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_base_s;
      return_pc_d   = redirect_base_s;
      outstanding_d = outstanding_q - CW'(imem_rvalid);
      discard_d     = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (grant_s) fetch_pc_d = fetch_pc_q + 32'd4;
      else         fetch_pc_d = fetch_pc_q;
      outstanding_d = outstanding_q + CW'(grant_s) - CW'(imem_rvalid);
      if (imem_rvalid && (discard_q != {CW{1'b0}})) discard_d = discard_q - CW'(1);
      else                                           discard_d = discard_q;
      if (push_s) return_pc_d = return_pc_q + 32'd4;
      else        return_pc_d = return_pc_q;
    end
  end

  // Front-end state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      return_pc_q   <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      discard_q     <= {CW{1'b0}};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      return_pc_q   <= return_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (redirect_valid),
    .wdata_i (push_entry_s),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_q;
  assign out_valid = !fifo_empty_s;
  assign out_pc    = fifo_empty_s ? {XLEN{1'b0}} : head_s.pc;
  assign out_instr = fifo_empty_s ? {XLEN{1'b0}} : head_s.instr;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: a randomized in-order memory responder plus
// a fetch-stream model (consecutive PCs from the last reset/redirect target).
module tb_instr_prefetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc, out_instr;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, last_due = 0, pops = 0, grants = 0;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] salt = 32'h0;
  logic [31:0] exp_fetch = RESET_PC, exp_out = RESET_PC, a0;
  logic        s_req, s_valid, s_fire;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the bus, sample mid-cycle, check against the model, advance.
  task automatic tick();
    pend_t p;
    int    lat;
    imem_gnt = (int'($urandom_range(99)) < gnt_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #3;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_fire  = imem_req && imem_gnt;
    if (!rst) begin
      if (redirect_valid) chk1("req_in_redirect", imem_req, 1'b0);
      if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
      chk1("credit_bound", (pend.size() + int'(s_fire)) <= int'(DEPTH), 1'b1);
      if (out_valid && out_ready && !redirect_valid) begin
        chk("out_pc", out_pc, exp_out);
        chk("out_instr", out_instr, mem_word(exp_out));
        exp_out += 32'd4;
        pops++;
      end
      if (!out_valid) begin
        chk("empty_pc", out_pc, 32'd0);
        chk("empty_instr", out_instr, 32'd0);
      end
    end
    if (rst) begin
      exp_fetch = RESET_PC;
      exp_out   = RESET_PC;
      pend.delete();
    end else if (redirect_valid) begin
      exp_fetch = {redirect_pc[31:2], 2'b00};
      exp_out   = {redirect_pc[31:2], 2'b00};
    end else if (s_fire) begin
      lat    = int'($urandom_range(lat_max, lat_min));
      p.addr = imem_addr;
      p.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = p.due;
      pend.push_back(p);
      exp_fetch += 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!s_valid && n < 20) begin
      tick();
      n++;
    end
    chk1(tag, s_valid, 1'b1);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    @(posedge clk);
    #1;

    // Reset, then first request and fill latency with a 1-cycle memory.
    tick();
    chk1("reset_req", s_req, 1'b0);
    rst = 1'b0;
    tick();
    chk1("first_req", s_req, 1'b1);
    chk("first_addr", s_addr, RESET_PC);
    chk1("reset_valid", s_valid, 1'b0);
    tick();
    chk1("fill_c1_valid", s_valid, 1'b0);
    tick();
    chk1("fill_c2_valid", s_valid, 1'b1);
    chk("first_pc", s_pc, 32'd0);
    chk("first_instr", s_instr, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("stream_valid", s_valid, 1'b1);
    end

    // Core stall: only DEPTH grants, then drain without gaps.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b0; grants = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      grants += int'(s_fire);
    end
    chk("stall_grants", 32'(grants), 32'(DEPTH));
    chk1("stall_req_off", s_req, 1'b0);
    chk("stall_head", s_pc, 32'h0000_0200);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("drain_valid", s_valid, 1'b1);
    end

    // Redirect with two slow responses in flight.
    lat_min = 3; lat_max = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    tick();
    wait_valid("redir_timeout");
    chk("redir_pc", s_pc, 32'h0000_0100);
    chk("redir_instr", s_instr, mem_word(32'h0000_0100));

    // Settle to a 1-cycle stream, then redirect while a response arrives.
    lat_min = 1; lat_max = 1; gnt_pct = 0;
    repeat (6) tick();
    gnt_pct = 100;
    repeat (8) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk1("redir_lat_c1", s_valid, 1'b0);
    tick();
    chk1("redir_lat_c2", s_valid, 1'b0);
    tick();
    chk1("redir_lat_c3", s_valid, 1'b1);
    chk("redir_lat_pc", s_pc, 32'h0000_0300);

    // Grant withheld: request and address hold, then a single +4.
    gnt_pct = 0; a0 = exp_fetch;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("hold_req", s_req, 1'b1);
      chk("hold_addr", s_addr, a0);
    end
    gnt_pct = 100;
    tick();
    chk("grant_addr", s_addr, a0);
    tick();
    chk("after_grant_addr", s_addr, a0 + 32'd4);

    // Address wrap at the top of memory.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_addr_hi", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr_lo", s_addr, 32'h0000_0000);
    repeat (4) tick();

    // Reset mid-stream, then a redirect every cycle holds the block idle.
    rst = 1'b1; salt = 32'h5A5A_C3C3;
    tick();
    rst = 1'b0;
    tick();
    chk1("midreset_valid", s_valid, 1'b0);
    chk("midreset_addr", s_addr, RESET_PC);
    redirect_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      redirect_pc = $urandom;
      tick();
      chk1("idle_req", s_req, 1'b0);
      chk1("idle_valid", s_valid, 1'b0);
    end
    redirect_valid = 1'b0;

    // Randomized traffic against the stream model.
    gnt_pct = 60; lat_min = 1; lat_max = 4; pops = 0;
    for (int i = 0; i < 3000; i++) begin
      out_ready      = (int'($urandom_range(99)) < 70);
      redirect_valid = (int'($urandom_range(99)) < 4);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    chk1("random_progress", pops > 500, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
